// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_controller_if : hazard/interrupt request and control bundle
// Rev 1.0
// ============================================================================
interface pipeline_hazard_controller_if #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
);
  logic [REG_IDX_WIDTH-1:0] id_reg_1_idx;
  logic [REG_IDX_WIDTH-1:0] id_reg_2_idx;
  logic                     id_reg_1_valid;
  logic                     id_reg_2_valid;
  logic [REG_IDX_WIDTH-1:0] ex_reg_dest_idx;
  logic                     ex_mem_read;
  logic                     id_branch_taken;
  logic                     input_enable;
  logic                     input_complete;
  logic                     cpu_pause;
  logic                     uart_request;
  logic                     uart_complete;

  logic [1:0]               if_hazard_control;
  logic [1:0]               id_hazard_control;
  logic [1:0]               ex_hazard_control;
  logic [1:0]               mem_hazard_control;
  logic [1:0]               wb_hazard_control;
  logic                     pc_reset;
  logic                     uart_disable;
  logic [2:0]               issue_type;
  logic [CNT_WIDTH-1:0]     stall_count;

  modport master (
    output id_reg_1_idx, id_reg_2_idx, id_reg_1_valid, id_reg_2_valid,
           ex_reg_dest_idx, ex_mem_read, id_branch_taken, input_enable,
           input_complete, cpu_pause, uart_request, uart_complete,
    input  if_hazard_control, id_hazard_control, ex_hazard_control,
           mem_hazard_control, wb_hazard_control, pc_reset, uart_disable,
           issue_type, stall_count
  );

  modport slave (
    input  id_reg_1_idx, id_reg_2_idx, id_reg_1_valid, id_reg_2_valid,
           ex_reg_dest_idx, ex_mem_read, id_branch_taken, input_enable,
           input_complete, cpu_pause, uart_request, uart_complete,
    output if_hazard_control, id_hazard_control, ex_hazard_control,
           mem_hazard_control, wb_hazard_control, pc_reset, uart_disable,
           issue_type, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_controller : load-use/branch hazards, keypad wait, pause and
// UART reload control for a 5-stage pipeline.  Rev 1.0
// ============================================================================
module pipeline_hazard_controller #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  pipeline_hazard_controller_if.slave bus
);

  localparam logic [1:0] c_NORMAL = 2'b00;
  localparam logic [1:0] c_STALL  = 2'b01;
  localparam logic [1:0] c_CLEAR  = 2'b10;

  localparam logic [2:0] c_ISSUE_NONE   = 3'd0;
  localparam logic [2:0] c_ISSUE_LOAD   = 3'd1;
  localparam logic [2:0] c_ISSUE_BRANCH = 3'd2;
  localparam logic [2:0] c_ISSUE_KEYPAD = 3'd3;
  localparam logic [2:0] c_ISSUE_PAUSE  = 3'd4;
  localparam logic [2:0] c_ISSUE_UART   = 3'd5;

  localparam logic [REG_IDX_WIDTH-1:0] c_IDX_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0]     c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_UART   = 2'd0,
    S_RUN    = 2'd1,
    S_KEYPAD = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic [1:0] w_if_ctrl;
  logic [1:0] w_id_ctrl;
  logic [1:0] w_ex_ctrl;
  logic [1:0] w_mem_ctrl;
  logic [1:0] w_wb_ctrl;
  logic       w_pc_reset;
  logic       w_uart_disable;
  logic [2:0] w_issue;
  logic       w_load_use;
  logic       w_keypad_wait;
  logic       w_any_stall;

  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_load_use = bus.ex_mem_read && (bus.ex_reg_dest_idx != c_IDX_ZERO) &&
                      ((bus.id_reg_1_valid && (bus.id_reg_1_idx == bus.ex_reg_dest_idx)) ||
                       (bus.id_reg_2_valid && (bus.id_reg_2_idx == bus.ex_reg_dest_idx)));

  assign w_keypad_wait = bus.input_enable && !bus.input_complete;

  always_comb begin
    w_next_state   = r_state;
    w_if_ctrl      = c_NORMAL;
    w_id_ctrl      = c_NORMAL;
    w_ex_ctrl      = c_NORMAL;
    w_mem_ctrl     = c_NORMAL;
    w_wb_ctrl      = c_NORMAL;
    w_pc_reset     = 1'b0;
    w_uart_disable = 1'b1;
    w_issue        = c_ISSUE_NONE;

    case (r_state)
      S_UART: begin
        w_if_ctrl      = c_CLEAR;
        w_id_ctrl      = c_CLEAR;
        w_ex_ctrl      = c_CLEAR;
        w_mem_ctrl     = c_CLEAR;
        w_wb_ctrl      = c_CLEAR;
        w_pc_reset     = 1'b1;
        w_uart_disable = 1'b0;
        w_issue        = c_ISSUE_UART;
        if (bus.uart_complete) begin
          w_next_state = S_RUN;
        end
      end

      S_RUN: begin
        // Keypad wait freezes everything up to MEM; load-use beats a taken branch.
        if (w_keypad_wait) begin
          w_if_ctrl  = c_STALL;
          w_id_ctrl  = c_STALL;
          w_ex_ctrl  = c_STALL;
          w_mem_ctrl = c_STALL;
          w_wb_ctrl  = c_CLEAR;
          w_issue    = c_ISSUE_KEYPAD;
        end else if (w_load_use) begin
          w_if_ctrl  = c_STALL;
          w_id_ctrl  = c_STALL;
          w_ex_ctrl  = c_CLEAR;
          w_issue    = c_ISSUE_LOAD;
        end else if (bus.id_branch_taken) begin
          w_id_ctrl  = c_CLEAR;
          w_issue    = c_ISSUE_BRANCH;
        end

        if (bus.uart_request) begin
          w_next_state = S_UART;
        end else if (w_keypad_wait) begin
          w_next_state = S_KEYPAD;
        end else if (bus.cpu_pause) begin
          w_next_state = S_PAUSE;
        end
      end

      S_KEYPAD: begin
        if (bus.input_complete) begin
          w_next_state = S_RUN;
        end else begin
          w_if_ctrl  = c_STALL;
          w_id_ctrl  = c_STALL;
          w_ex_ctrl  = c_STALL;
          w_mem_ctrl = c_STALL;
          w_wb_ctrl  = c_CLEAR;
          w_issue    = c_ISSUE_KEYPAD;
        end
      end

      S_PAUSE: begin
        w_if_ctrl  = c_STALL;
        w_id_ctrl  = c_STALL;
        w_ex_ctrl  = c_STALL;
        w_mem_ctrl = c_STALL;
        w_wb_ctrl  = c_STALL;
        w_issue    = c_ISSUE_PAUSE;
        if (bus.uart_request) begin
          w_next_state = S_UART;
        end else if (bus.cpu_pause) begin
          w_next_state = S_RUN;
        end
      end

      default: begin
        w_next_state = S_UART;
      end
    endcase
  end

  assign w_any_stall = (w_if_ctrl == c_STALL) || (w_id_ctrl == c_STALL) ||
                       (w_ex_ctrl == c_STALL) || (w_mem_ctrl == c_STALL) ||
                       (w_wb_ctrl == c_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_UART;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_any_stall && (r_stall_count != c_CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.if_hazard_control  = w_if_ctrl;
  assign bus.id_hazard_control  = w_id_ctrl;
  assign bus.ex_hazard_control  = w_ex_ctrl;
  assign bus.mem_hazard_control = w_mem_ctrl;
  assign bus.wb_hazard_control  = w_wb_ctrl;
  assign bus.pc_reset           = w_pc_reset;
  assign bus.uart_disable       = w_uart_disable;
  assign bus.issue_type         = w_issue;
  assign bus.stall_count        = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for pipeline_hazard_controller: directed stimulus, an issue-code model
// checked every negedge, plus literal expectations at key points.
module tb_pipeline_hazard_controller;
  localparam int RW      = 5;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [9:0] K_NONE   = 10'b00_00_00_00_00;
  localparam logic [9:0] K_LOAD   = 10'b01_01_10_00_00;
  localparam logic [9:0] K_BRANCH = 10'b00_10_00_00_00;
  localparam logic [9:0] K_KEYPAD = 10'b01_01_01_01_10;
  localparam logic [9:0] K_PAUSE  = 10'b01_01_01_01_01;
  localparam logic [9:0] K_UART   = 10'b10_10_10_10_10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   m_mode = 0;   // 0 UART, 1 RUN, 2 KEYPAD, 3 PAUSE
  int   m_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.REG_IDX_WIDTH(RW), .CNT_WIDTH(CW)) bus ();
  pipeline_hazard_controller #(.REG_IDX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ctrl_now();
    return {bus.if_hazard_control, bus.id_hazard_control, bus.ex_hazard_control,
            bus.mem_hazard_control, bus.wb_hazard_control};
  endfunction

  function automatic int exp_issue(input int mode);
    bit lu;
    lu = bus.ex_mem_read && (bus.ex_reg_dest_idx != 0) &&
         ((bus.id_reg_1_valid && bus.id_reg_1_idx == bus.ex_reg_dest_idx) ||
          (bus.id_reg_2_valid && bus.id_reg_2_idx == bus.ex_reg_dest_idx));
    case (mode)
      0: return 5;
      2: return bus.input_complete ? 0 : 3;
      3: return 4;
      default: begin
        if (bus.input_enable && !bus.input_complete) return 3;
        if (lu) return 1;
        if (bus.id_branch_taken) return 2;
        return 0;
      end
    endcase
  endfunction

  function automatic int next_mode(input int mode);
    case (mode)
      0: return bus.uart_complete ? 1 : 0;
      2: return bus.input_complete ? 1 : 2;
      3: return bus.uart_request ? 0 : (bus.cpu_pause ? 1 : 3);
      default: begin
        if (bus.uart_request) return 0;
        if (bus.input_enable && !bus.input_complete) return 2;
        if (bus.cpu_pause) return 3;
        return 1;
      end
    endcase
  endfunction

  function automatic logic [9:0] ctrl_of(input int issue);
    case (issue)
      1: return K_LOAD;
      2: return K_BRANCH;
      3: return K_KEYPAD;
      4: return K_PAUSE;
      5: return K_UART;
      default: return K_NONE;
    endcase
  endfunction

  // Model: mode and stall counter advance on the clock; stalls are issues 1, 3 and 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_cnt  <= 0;
    end else begin
      if ((exp_issue(m_mode) inside {1, 3, 4}) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      m_mode <= next_mode(m_mode);
    end
  end

  always @(negedge clk) begin
    chk("m_ctrl", 32'(ctrl_now()), 32'(ctrl_of(exp_issue(m_mode))));
    chk("m_issue", 32'(bus.issue_type), 32'(exp_issue(m_mode)));
    chk("m_pc_reset", 32'(bus.pc_reset), 32'(exp_issue(m_mode) == 5));
    chk("m_uart_dis", 32'(bus.uart_disable), 32'(exp_issue(m_mode) != 5));
    chk("m_stall_cnt", 32'(bus.stall_count), 32'(m_cnt));
  end

  task automatic expect_out(input string name, input logic [9:0] ctrl, input int issue,
                            input bit pc, input bit ud, input int cnt);
    chk({name, "_ctrl"}, 32'(ctrl_now()), 32'(ctrl));
    chk({name, "_issue"}, 32'(bus.issue_type), 32'(issue));
    chk({name, "_pc"}, 32'(bus.pc_reset), 32'(pc));
    chk({name, "_ud"}, 32'(bus.uart_disable), 32'(ud));
    chk({name, "_cnt"}, 32'(bus.stall_count), 32'(cnt));
  endtask

  task automatic clr_in();
    bus.id_reg_1_idx    = '0;
    bus.id_reg_2_idx    = '0;
    bus.id_reg_1_valid  = 1'b0;
    bus.id_reg_2_valid  = 1'b0;
    bus.ex_reg_dest_idx = '0;
    bus.ex_mem_read     = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.input_enable    = 1'b0;
    bus.input_complete  = 1'b0;
    bus.cpu_pause       = 1'b0;
    bus.uart_request    = 1'b0;
    bus.uart_complete   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    #2 expect_out("reset", K_UART, 5, 1, 0, 0);
    #10 rst_n = 1'b1;

    step(); bus.uart_complete = 1'b1;
    #2 expect_out("uart_hold", K_UART, 5, 1, 0, 0);
    step(); bus.uart_complete = 1'b0;
    #2 expect_out("run_idle", K_NONE, 0, 0, 1, 0);

    // Load-use with a simultaneous taken branch, then the same with dest = r0.
    step();
    bus.ex_mem_read = 1'b1; bus.ex_reg_dest_idx = 5'd8;
    bus.id_reg_2_idx = 5'd8; bus.id_reg_2_valid = 1'b1; bus.id_branch_taken = 1'b1;
    #2 expect_out("load_use", K_LOAD, 1, 0, 1, 0);
    step(); bus.ex_reg_dest_idx = 5'd0; bus.id_branch_taken = 1'b0;
    #2 expect_out("lu_dest0", K_NONE, 0, 0, 1, 1);
    step(); clr_in(); bus.id_branch_taken = 1'b1;
    #2 expect_out("branch", K_BRANCH, 2, 0, 1, 1);

    // Keypad wait of four cycles; a pause pulse inside it must be ignored.
    step(); clr_in(); bus.input_enable = 1'b1;
    #2 expect_out("kp_enter", K_KEYPAD, 3, 0, 1, 1);
    step(); #2 expect_out("kp_hold2", K_KEYPAD, 3, 0, 1, 2);
    step(); bus.cpu_pause = 1'b1;
    #2 expect_out("kp_pause_ign", K_KEYPAD, 3, 0, 1, 3);
    step(); bus.cpu_pause = 1'b0;
    #2 expect_out("kp_hold4", K_KEYPAD, 3, 0, 1, 4);
    step(); bus.input_complete = 1'b1;
    #2 expect_out("kp_done", K_NONE, 0, 0, 1, 5);
    step(); clr_in();
    #2 expect_out("kp_back_run", K_NONE, 0, 0, 1, 5);

    // Pause for three cycles, exit on a second pulse.
    step(); bus.cpu_pause = 1'b1;
    #2 expect_out("pause_req", K_NONE, 0, 0, 1, 5);
    step(); bus.cpu_pause = 1'b0;
    #2 expect_out("pause1", K_PAUSE, 4, 0, 1, 5);
    step(); #2 expect_out("pause2", K_PAUSE, 4, 0, 1, 6);
    step(); bus.cpu_pause = 1'b1;
    #2 expect_out("pause3", K_PAUSE, 4, 0, 1, 7);
    step(); clr_in();
    #2 expect_out("pause_exit", K_NONE, 0, 0, 1, 8);

    // Enter and complete in the same cycle: no keypad stall, load-use still applies.
    step();
    bus.ex_mem_read = 1'b1; bus.ex_reg_dest_idx = 5'd3;
    bus.id_reg_1_idx = 5'd3; bus.id_reg_1_valid = 1'b1;
    bus.input_enable = 1'b1; bus.input_complete = 1'b1;
    #2 expect_out("lu_with_ic", K_LOAD, 1, 0, 1, 8);
    step(); clr_in();
    #2 expect_out("after_lu_ic", K_NONE, 0, 0, 1, 9);
    step();
    bus.ex_mem_read = 1'b1; bus.ex_reg_dest_idx = 5'd3;
    bus.id_reg_1_idx = 5'd3; bus.id_reg_2_idx = 5'd3;
    #2 expect_out("lu_invalid_src", K_NONE, 0, 0, 1, 9);

    // uart_request wins over cpu_pause while paused.
    step(); clr_in(); bus.cpu_pause = 1'b1;
    #2 expect_out("pause_req2", K_NONE, 0, 0, 1, 9);
    step(); bus.uart_request = 1'b1;
    #2 expect_out("pause_uart", K_PAUSE, 4, 0, 1, 9);
    step(); clr_in();
    #2 expect_out("uart_from_pause", K_UART, 5, 1, 0, 10);
    step(); bus.uart_complete = 1'b1;
    #2 expect_out("uart_done", K_UART, 5, 1, 0, 10);

    // Asynchronous reset in the middle of a keypad wait.
    step(); clr_in(); bus.input_enable = 1'b1;
    #2 expect_out("kp2_enter", K_KEYPAD, 3, 0, 1, 10);
    step(); bus.uart_request = 1'b1;
    #2 expect_out("kp_uart_ign", K_KEYPAD, 3, 0, 1, 11);
    step(); bus.uart_request = 1'b0;
    #2 expect_out("kp2_hold", K_KEYPAD, 3, 0, 1, 12);
    rst_n = 1'b0;
    #1 expect_out("async_reset", K_UART, 5, 1, 0, 0);
    #2 rst_n = 1'b1;
    clr_in();
    step(); bus.uart_complete = 1'b1;
    #2 expect_out("uart_after_rst", K_UART, 5, 1, 0, 0);
    step(); clr_in();
    #2 expect_out("run_after_rst", K_NONE, 0, 0, 1, 0);

    // Long pause drives the narrow counter into saturation.
    step(); bus.cpu_pause = 1'b1;
    step(); bus.cpu_pause = 1'b0;
    repeat (39) step();
    #2 expect_out("saturate", K_PAUSE, 4, 0, 1, CNT_MAX);
    step(); bus.cpu_pause = 1'b1;
    #2 expect_out("sat_hold", K_PAUSE, 4, 0, 1, CNT_MAX);
    step(); clr_in();
    #2 expect_out("sat_run", K_NONE, 0, 0, 1, CNT_MAX);

    step(); bus.uart_request = 1'b1;
    #2 expect_out("run_uart_req", K_NONE, 0, 0, 1, CNT_MAX);
    step(); clr_in();
    #2 expect_out("run_to_uart", K_UART, 5, 1, 0, CNT_MAX);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
